return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Return-address LIFO that executes the push/pop requests issued by the control unit for JCALL and JR.
- On JCALL it stores the return address (PC+1). On JR it presents the top entry combinationally, so the PC source mux (s_pila) can select it in the same cycle.
- Sits beside the PC register in the single-cycle datapath.
- Adds a small sequential layer on top of the storage array: occupancy tracking, full/empty detection, and a sticky error state.

Parameters:
- ADDR_W, 10, width of a stored return address (program-memory address width).
- DEPTH, 16, number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  rising-edge clock, shared with the PC and register file.
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- push  in  1  write din on top; from uc (JCALL).
- pop  in  1  discard top entry; from uc (JR).
- din  in  ADDR_W  return address to store (PC+1).
- clr_err  in  1  leave ERROR state; clears both sticky flags.
- dout  out  ADDR_W  current top entry, combinational; 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- error  out  1  high while the state machine is in ERROR.

Behaviour:
- State machine: two states, RUN and ERROR. reset low at a clock edge → RUN, count=0, overflow=0, underflow=0. The storage array is not cleared.
- Reset values of outputs: dout=0, empty=1, full=0, count=0, overflow=0, underflow=0, error=0.
- Reset takes priority over every other input. A push or pop in the same cycle as reset is lost.
- dout = mem[count-1] when count>0, else 0. It is purely combinational from count and the array; there is zero latency for JR.
- All state updates happen on the rising clk edge. The RUN-state cases are:
  - push only, not full: mem[count] ← din; count+1.
  - pop only, not empty: count-1. Array is untouched.
  - push and pop, not empty: the top is replaced in place, mem[count-1] ← din; count unchanged. This covers CALL immediately after RET in the same cycle.
  - push and pop, empty: treated as push only.
  - push only, full: no write; count unchanged; overflow←1; state→ERROR.
  - pop only, empty: count unchanged; underflow←1; state→ERROR.
  - neither: hold.
- ERROR state:
  - push and pop are ignored; count and the array are frozen.
  - dout still shows the frozen top.
  - error=1.
  - clr_err=1 → RUN with overflow=0 and underflow=0. Any push or pop in the same cycle as clr_err is ignored.
- clr_err in RUN has no effect.
- Wrap-around: the write index is always count (or count-1 for a replace) and never wraps. Full and empty are decided from count only, never from pointer comparison.
- The width of count allows it to equal DEPTH exactly.
- The block does not check the z flag. Qualifying push/pop by the condition is the control unit's responsibility.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W_DEF=10.
  - STACK_DEPTH_DEF=16.
  - The state encoding ST_RUN=1'b0, ST_ERR=1'b1.
- One sub-module, stack_mem:
  - DEPTH×ADDR_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- return_stack contains the FSM, the counter, the flags, and the index/mux logic.

Test Plan:
- Reset with reset=0 for 2 cycles while push=1, din=0x3FF → count=0, empty=1, dout=0, error=0; no entry is stored.
- Push 0x005, 0x012, 0x1A0 on consecutive cycles, then pop 3× → dout reads 0x1A0, 0x012, 0x005 in the cycle before each pop edge. Afterwards count=0, empty=1, dout=0.
- With count=2 and top=0x012, assert push and pop together with din=0x2F0 → count stays 2, dout=0x2F0, the entry below is unchanged. The same stimulus with empty → count=1, dout=0x2F0.
- Fill 16 entries → full=1, count=16. A 17th push with din=0x0AA → overflow=1, error=1, dout unchanged. Further pushes and pops are ignored. clr_err=1 → error=0, overflow=0, count=16.
- Pop when empty → underflow=1, error=1, count=0. A push during ERROR is ignored. After clr_err, push 0x044 → count=1, dout=0x044.
- Reset asserted mid-sequence with count=5 → the next cycle shows count=0, empty=1, overflow=0, underflow=0, error=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath sizes and the return-stack state encoding.
package cpu_pkg;
   localparam int ADDR_W_DEF      = 10;
   localparam int STACK_DEPTH_DEF = 16;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_ERR = 1'b1
   } rs_state_t;
endpackage

// File: rtl/stack_mem.sv
// Return-address storage: register array with one synchronous write and one asynchronous read port.
module stack_mem #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rdata
);
   logic [ADDR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/return_stack.sv
// Return-address LIFO for JCALL/JR with occupancy tracking and a sticky RUN/ERROR state machine.
module return_stack
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = STACK_DEPTH_DEF,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow,
   output logic              error
);
   localparam int IDX_W = $clog2(DEPTH);

   rs_state_t         state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              we;
   logic [IDX_W-1:0]  waddr;
   logic [IDX_W-1:0]  top_idx;
   logic [ADDR_W-1:0] rdata;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign top_idx = IDX_W'(count_q - 1'b1);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      we          = 1'b0;
      waddr       = IDX_W'(count_q);
      case (state_q)
         ST_RUN: begin
            if (push && pop && !empty) begin
               // CALL right after RET: overwrite the top in place
               we    = 1'b1;
               waddr = top_idx;
            end else if (push) begin
               if (full) begin
                  overflow_d = 1'b1;
                  state_d    = ST_ERR;
               end else begin
                  we      = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end else if (pop) begin
               if (empty) begin
                  underflow_d = 1'b1;
                  state_d     = ST_ERR;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
         ST_ERR: begin
            if (clr_err) begin
               state_d     = ST_RUN;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // A write in the reset cycle must be lost, so gate the array enable with reset
   stack_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (we & reset),
      .waddr (waddr),
      .wdata (din),
      .raddr (top_idx),
      .rdata (rdata)
   );

   assign dout      = empty ? '0 : rdata;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign error     = (state_q == ST_ERR);
endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: directed scenarios followed by random traffic against a queue-based model.
module tb_return_stack;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic [ADDR_W-1:0] din = '0;
   logic              clr_err = 1'b0;
   logic [ADDR_W-1:0] dout;
   logic              empty, full, overflow, underflow, error;
   logic [CNT_W-1:0]  count;

   return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .clr_err   (clr_err),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                step;
      logic [ADDR_W-1:0] dout;
      logic [CNT_W-1:0]  count;
      logic              empty;
      logic              full;
      logic              ovf;
      logic              unf;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step    = 0;
   bit   drv_done = 1'b0;

   // Reference model: the stack as a plain queue of addresses plus flags
   int   m_stk[$];
   bit   m_err = 0, m_ovf = 0, m_unf = 0;

   function automatic void model_step(bit r, bit ps, bit pp, int d, bit clr);
      if (!r) begin
         m_stk.delete();
         m_err = 0; m_ovf = 0; m_unf = 0;
      end else if (m_err) begin
         if (clr) begin
            m_err = 0; m_ovf = 0; m_unf = 0;
         end
      end else if (ps && pp && m_stk.size() > 0) begin
         m_stk[m_stk.size()-1] = d;
      end else if (ps) begin
         if (m_stk.size() == DEPTH) begin
            m_ovf = 1; m_err = 1;
         end else begin
            m_stk.push_back(d);
         end
      end else if (pp) begin
         if (m_stk.size() == 0) begin
            m_unf = 1; m_err = 1;
         end else begin
            void'(m_stk.pop_back());
         end
      end
   endfunction

   task automatic cyc(bit r, bit ps, bit pp, int d, bit clr);
      exp_t e;
      @(negedge clk);
      reset = r; push = ps; pop = pp; din = ADDR_W'(d); clr_err = clr;
      @(posedge clk);
      model_step(r, ps, pp, d, clr);
      step++;
      e.step  = step;
      e.count = CNT_W'(m_stk.size());
      e.dout  = (m_stk.size() > 0) ? ADDR_W'(m_stk[m_stk.size()-1]) : '0;
      e.empty = (m_stk.size() == 0);
      e.full  = (m_stk.size() == DEPTH);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the settled outputs after every edge the driver has predicted
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (dout !== e.dout || count !== e.count || empty !== e.empty || full !== e.full ||
                overflow !== e.ovf || underflow !== e.unf || error !== e.err) begin
               n_fail++;
               $display("FAIL step%0d: got dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b err=%b, want dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b err=%b",
                        e.step, dout, count, empty, full, overflow, underflow, error,
                        e.dout, e.count, e.empty, e.full, e.ovf, e.unf, e.err);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with a push pending: nothing may be stored
      cyc(0, 1, 0, 'h3FF, 0);
      cyc(0, 1, 0, 'h3FF, 0);
      // Basic LIFO order
      cyc(1, 1, 0, 'h005, 0);
      cyc(1, 1, 0, 'h012, 0);
      cyc(1, 1, 0, 'h1A0, 0);
      repeat (3) cyc(1, 0, 1, 0, 0);
      // Replace in place with two entries, then with the stack empty
      cyc(1, 1, 0, 'h005, 0);
      cyc(1, 1, 0, 'h012, 0);
      cyc(1, 1, 1, 'h2F0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(1, 1, 1, 'h2F0, 0);
      cyc(1, 0, 1, 0, 0);
      // Fill, overflow, frozen error state, recovery
      for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 'h100 + i * 7, 0);
      cyc(1, 1, 0, 'h0AA, 0);
      cyc(1, 1, 0, 'h0BB, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(1, 1, 1, 'h0CC, 0);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 1, 1, 'h0DD, 0);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0);
      // Underflow, ignored push, clr_err with a pop in the same cycle
      cyc(1, 0, 1, 0, 0);
      cyc(1, 1, 0, 'h033, 0);
      cyc(1, 0, 1, 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 1, 0, 'h044, 0);
      // Reset mid-sequence at count 5
      repeat (4) cyc(1, 1, 0, $urandom_range(0, 1023), 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      // Random traffic, biased so the stack reaches both ends
      for (int i = 0; i < 3000; i++) begin
         int  k;
         bit  ps, pp, clr, r;
         k   = $urandom_range(0, 99);
         ps  = (k < 45) || (k >= 90);
         pp  = (k >= 40);
         clr = ($urandom_range(0, 9) == 0);
         r   = ($urandom_range(0, 199) != 0);
         if (i % 600 < 300) pp = pp && ($urandom_range(0, 2) == 0);
         cyc(r, ps, pp, $urandom_range(0, 1023), clr);
      end
      @(negedge clk);
      push = 0; pop = 0; clr_err = 0;
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      drv_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
